// File: rtl/td4_cpu_if.sv
// Board-side bus of the TD4 CPU: program-store address/opcode plus switches and LEDs.
interface td4_cpu_if;
  logic       addr;
  logic [3:0] data;
  logic [3:0] switch;
  logic [3:0] led;

  modport master (output addr, output led, input data, input switch);
  modport slave  (input addr, input led, output data, output switch);
endinterface

// File: rtl/td4_cpu.sv
// TD4-style 4-bit accumulator CPU: one opcode per clock through a single adder.
module td4_cpu (
  input  logic       clk,
  input  logic       n_rst,
  td4_cpu_if.master  bus
);
  localparam logic [3:0] IM = 4'b0000;

  logic [3:0] a, b, out_q, pc;
  logic       c;
  logic [3:0] src;
  logic [4:0] sum;
  logic       write_a, write_b, write_o, jump;

  always_comb begin
    src     = '0;
    write_a = 1'b0;
    write_b = 1'b0;
    write_o = 1'b0;
    jump    = 1'b0;
    case (bus.data)
      4'b0000: begin src = a;          write_a = 1'b1; end
      4'b0001: begin src = b;          write_a = 1'b1; end
      4'b0010: begin src = bus.switch; write_a = 1'b1; end
      4'b0011: begin src = IM;         write_a = 1'b1; end
      4'b0100: begin src = a;          write_b = 1'b1; end
      4'b0101: begin src = b;          write_b = 1'b1; end
      4'b0110: begin src = bus.switch; write_b = 1'b1; end
      4'b0111: begin src = IM;         write_b = 1'b1; end
      4'b1001: begin src = b;          write_o = 1'b1; end
      4'b1011: begin src = IM;         write_o = 1'b1; end
      // JNC tests the carry left by the previous instruction
      4'b1110: begin src = IM;         jump = ~c;      end
      4'b1111: begin src = IM;         jump = 1'b1;    end
      default: ;
    endcase
    sum = {1'b0, src} + {1'b0, IM};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a     <= '0;
      b     <= '0;
      out_q <= '0;
      pc    <= '0;
      c     <= 1'b0;
    end else begin
      if (write_a) a     <= sum[3:0];
      if (write_b) b     <= sum[3:0];
      if (write_o) out_q <= sum[3:0];
      pc <= jump ? sum[3:0] : pc + 4'd1;
      c  <= sum[4];
    end
  end

  assign bus.led  = out_q;
  assign bus.addr = pc[0];
endmodule

// File: tb/tb_td4_cpu.sv
// Bench for td4_cpu: directed plan with literal expectations plus random programs vs a model.
module tb_td4_cpu;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  td4_cpu_if bus ();

  td4_cpu dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit compare_on = 1'b0;

  // Architectural model: plain register file and integer arithmetic.
  int m_a = 0, m_b = 0, m_out = 0, m_pc = 0, m_c = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge n_rst) begin
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
  end

  always @(posedge clk) begin
    if (n_rst) begin
      int op, sw, res;
      bit jumped;
      op = int'(bus.data);
      sw = int'(bus.switch);
      jumped = 1'b0;
      res = 0;
      case (op)
        0:  begin res = m_a + 0; m_a = res % 16; end
        1:  begin res = m_b;     m_a = res; end
        2:  begin res = sw;      m_a = res; end
        3:  begin res = 0;       m_a = res; end
        4:  begin res = m_a;     m_b = res; end
        5:  begin res = m_b + 0; m_b = res % 16; end
        6:  begin res = sw;      m_b = res; end
        7:  begin res = 0;       m_b = res; end
        9:  begin res = m_b;     m_out = res; end
        11: begin res = 0;       m_out = res; end
        14: if (m_c == 0) begin m_pc = 0; jumped = 1'b1; end
        15: begin m_pc = 0; jumped = 1'b1; end
        default: ;
      endcase
      if (!jumped) m_pc = (m_pc + 1) % 16;
      m_c = (res > 15) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      check("model_led", int'(bus.led), m_out);
      check("model_addr", int'(bus.addr), m_pc % 2);
    end
  end

  task automatic step(input logic [3:0] d, input logic [3:0] s);
    @(negedge clk);
    #1;
    bus.data = d;
    bus.switch = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.data = 4'b0010;
    bus.switch = 4'd5;
    #1 n_rst = 1'b0;
    #1;
    check("reset_led_async", int'(bus.led), 0);
    check("reset_addr_async", int'(bus.addr), 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_led", int'(bus.led), 0);
    check("reset_hold_addr", int'(bus.addr), 0);
    compare_on = 1'b1;
    @(negedge clk);
    #1;
    bus.data = 4'b0100;
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("first_exec_addr", int'(bus.addr), 1);
    step(4'b1001, 4'd0);
    check("a_held_in_reset", int'(bus.led), 0);

    step(4'b0010, 4'd3);
    step(4'b0100, 4'd0);
    step(4'b1001, 4'd0);
    check("in_a_out_led", int'(bus.led), 3);

    step(4'b0110, 4'd6);
    step(4'b0001, 4'd0);
    step(4'b1001, 4'd0);
    check("in_b_out_led", int'(bus.led), 6);
    step(4'b0000, 4'd0);
    begin
      int first;
      first = int'(bus.addr);
      step(4'b0000, 4'd0);
      check("pc_toggle1", int'(bus.addr), 1 - first);
      step(4'b0000, 4'd0);
      check("pc_toggle2", int'(bus.addr), first);
    end
    check("add_a_keeps_led", int'(bus.led), 6);
    step(4'b0100, 4'd0);
    step(4'b1001, 4'd0);
    check("add_a_keeps_a", int'(bus.led), 6);

    step(4'b0011, 4'd9);
    step(4'b0111, 4'd9);
    step(4'b1001, 4'd0);
    check("mov_b_im", int'(bus.led), 0);
    step(4'b0110, 4'd6);
    step(4'b1001, 4'd0);
    step(4'b1011, 4'd0);
    check("out_im", int'(bus.led), 0);
    step(4'b1001, 4'd0);
    check("reload_led", int'(bus.led), 6);

    step(4'b1000, 4'd0);
    step(4'b1010, 4'd0);
    step(4'b1100, 4'd0);
    check("nop_pc_inc", int'(bus.addr), (int'(dut.pc) % 2));
    step(4'b1101, 4'd0);
    check("nop_led", int'(bus.led), 6);
    step(4'b1001, 4'd0);
    check("nop_keeps_b", int'(bus.led), 6);

    step(4'b0000, 4'd0);
    step(4'b1111, 4'd0);
    check("jmp_addr", int'(bus.addr), 0);
    step(4'b0000, 4'd0);
    check("after_jmp_addr", int'(bus.addr), 1);
    step(4'b1110, 4'd0);
    check("jnc_addr", int'(bus.addr), 0);

    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid_reset_led", int'(bus.led), 0);
    check("mid_reset_addr", int'(bus.addr), 0);
    #1 n_rst = 1'b1;

    for (int i = 0; i < 600; i++) begin
      logic [3:0] d, s;
      d = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      step(d, s);
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rand_reset_led", int'(bus.led), 0);
        #1 n_rst = 1'b1;
      end
    end

    @(negedge clk);
    compare_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
